// File: rtl/instr_fetch_decode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : instr_fetch_decode_pkg                                           |
// | Brief   : Shared FSM encoding, instruction field positions and defaults    |
// |           for the fetch/decode front end.                                  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package instr_fetch_decode_pkg;

  localparam int INSTR_BITS = 16;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 11;
  localparam int RD_MSB = 10;
  localparam int RD_LSB = 8;
  localparam int RA_MSB = 7;
  localparam int RA_LSB = 5;
  localparam int RB_MSB = 4;
  localparam int RB_LSB = 2;
  localparam int IMM5_MSB  = 4;
  localparam int IMM8_MSB  = 7;
  localparam int IMM11_MSB = 10;

  localparam logic [4:0] HALT_OP_DEFAULT = 5'b11111;

  // Legacy-compatible state encoding shared with the sequencer tooling
  typedef logic [1:0] ifd_state_t;
  localparam ifd_state_t ST_IDLE  = 2'd0;
  localparam ifd_state_t ST_FETCH = 2'd1;
  localparam ifd_state_t ST_DRAIN = 2'd2;
  localparam ifd_state_t ST_HALT  = 2'd3;

  function automatic logic [OP_MSB-OP_LSB:0] instr_opcode(input logic [INSTR_BITS-1:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_decode_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : instr_fetch_decode_if                                            |
// | Brief   : Instruction-memory handshake, redirect/stall controls and        |
// |           decoded-field bundle for the fetch/decode stage.                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface instr_fetch_decode_if
  import instr_fetch_decode_pkg::*;
#(
  parameter int BITS    = 16,
  parameter int OP_BITS = 5
);

  logic                  imem_req;
  logic [BITS-1:0]       imem_addr;
  logic                  imem_ack;
  logic [INSTR_BITS-1:0] imem_rdata;

  logic                  stall;
  logic                  branch_taken;
  logic [BITS-1:0]       branch_target;

  logic                  instr_valid;
  logic [BITS-1:0]       instr_pc;
  logic [OP_BITS-1:0]    opcode;
  logic [2:0]            rd;
  logic [2:0]            ra;
  logic [2:0]            rb;
  logic [4:0]            imm5;
  logic [7:0]            imm8;
  logic [10:0]           imm11;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  stall, branch_taken, branch_target,
    output instr_valid, instr_pc, opcode, rd, ra, rb, imm5, imm8, imm11
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output stall, branch_taken, branch_target,
    input  instr_valid, instr_pc, opcode, rd, ra, rb, imm5, imm8, imm11
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_decode_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ifd_skid_buf                                                     |
// | Brief   : One-entry data+valid holding register with load, pop and flush.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ifd_skid_buf
  import instr_fetch_decode_pkg::*;
#(
  parameter int WIDTH = 2 * INSTR_BITS
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic             pop,
  input  wire logic             flush,
  input  wire logic [WIDTH-1:0] din,
  output logic                  full,
  output logic [WIDTH-1:0]      dout
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Flush wins over a same-cycle load so a redirect never leaves stale data behind
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d = 1'b1;
      data_d = din;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign dout = data_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : instr_fetch_decode                                               |
// | Brief   : Fetches 16-bit instructions over req/ack, holds them in the IR   |
// |           with a one-entry skid, and slices out the decode fields.         |
// |           Optional halt support is enabled by defining IFD_HALT_EN.        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int              BITS     = 16,
  parameter int              OP_BITS  = 5,
  parameter logic [BITS-1:0] RESET_PC = '0
`ifdef IFD_HALT_EN
  ,
  parameter logic [OP_BITS-1:0] HALT_OP = HALT_OP_DEFAULT
`endif
) (
  input  wire logic           clk,
  input  wire logic           rst,
  instr_fetch_decode_if.master bus
);

  localparam int SKID_W = INSTR_BITS + BITS;

  ifd_state_t            state_q, state_d;
  logic [BITS-1:0]       pc_q, pc_d;
  logic [BITS-1:0]       addr_q, addr_d;
  logic [INSTR_BITS-1:0] ir_q, ir_d;
  logic [BITS-1:0]       ir_pc_q, ir_pc_d;
  logic                  valid_q, valid_d;

  logic                  skid_full;
  logic                  skid_load;
  logic                  skid_pop;
  logic                  skid_flush;
  logic [SKID_W-1:0]     skid_dout;

  logic                  req;
  logic                  accept;
  logic                  ir_free;
  logic                  consume;
  logic                  halt_hit;

  assign req     = ((state_q == ST_FETCH) || (state_q == ST_DRAIN)) && !skid_full;
  // Acks seen in DRAIN, or coinciding with a redirect, belong to a dead fetch
  assign accept  = req && bus.imem_ack && (state_q == ST_FETCH) && !bus.branch_taken;
  assign ir_free = !valid_q || !bus.stall;
  assign consume = valid_q && !bus.stall;

`ifdef IFD_HALT_EN
  assign halt_hit = accept && (instr_opcode(bus.imem_rdata) == HALT_OP);
`else
  assign halt_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.branch_taken) begin
          state_d = (req && !bus.imem_ack) ? ST_DRAIN : ST_FETCH;
        end else if (halt_hit) begin
          state_d = ST_HALT;
        end
      end
      ST_DRAIN: begin
        if (bus.imem_ack) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        if (bus.branch_taken) begin
          state_d = ST_FETCH;
        end
      end
    endcase
  end

  // addr_q tracks the address on the bus so DRAIN keeps presenting the old request
  always_comb begin
    pc_d   = pc_q;
    addr_d = (state_q == ST_FETCH) ? pc_q : addr_q;
    if (bus.branch_taken) begin
      pc_d = bus.branch_target;
    end else if (accept) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_comb begin
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_pop   = 1'b0;
    skid_flush = 1'b0;
    if (bus.branch_taken) begin
      valid_d    = 1'b0;
      skid_flush = 1'b1;
    end else begin
      if (consume) begin
        if (skid_full) begin
          ir_d     = skid_dout[SKID_W-1 -: INSTR_BITS];
          ir_pc_d  = skid_dout[BITS-1:0];
          valid_d  = 1'b1;
          skid_pop = 1'b1;
        end else if (!accept) begin
          valid_d  = 1'b0;
        end
      end
      // accept implies an empty skid, so it never collides with the pop above
      if (accept) begin
        if (ir_free) begin
          ir_d    = bus.imem_rdata;
          ir_pc_d = pc_q;
          valid_d = 1'b1;
        end else begin
          skid_load = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ir_q    <= '0;
      ir_pc_q <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      valid_q <= valid_d;
    end
  end

  ifd_skid_buf #(
    .WIDTH (SKID_W)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .pop   (skid_pop),
    .flush (skid_flush),
    .din   ({bus.imem_rdata, pc_q}),
    .full  (skid_full),
    .dout  (skid_dout)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = (state_q == ST_DRAIN) ? addr_q : pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_pc    = ir_pc_q;
  assign bus.opcode      = ir_q[OP_MSB:OP_LSB];
  assign bus.rd          = ir_q[RD_MSB:RD_LSB];
  assign bus.ra          = ir_q[RA_MSB:RA_LSB];
  assign bus.rb          = ir_q[RB_MSB:RB_LSB];
  assign bus.imm5        = ir_q[IMM5_MSB:0];
  assign bus.imm8        = ir_q[IMM8_MSB:0];
  assign bus.imm11       = ir_q[IMM11_MSB:0];

endmodule
`default_nettype wire

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Front-end stage that fetches 16-bit instructions from instruction memory over a req/ack handshake, holds them in an instruction register, and splits each into the opcode, register and immediate fields. These fields feed the register file and the B-bus operand select stage. Handles downstream stalls with a one-entry skid buffer and branch redirects with flush and in-flight-request drain.

## Interface
- BITS, 16, data/address width
- OP_BITS, 5, opcode width
- RESET_PC, 0, PC value loaded on reset
- HALT_OP, 5'b11111, halt opcode (used only when IFD_HALT_EN is defined)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- imem_req  out  1  fetch request
- imem_addr  out  BITS  fetch address (word address)
- imem_ack  in  1  request complete; imem_rdata valid this cycle
- imem_rdata  in  16  instruction word
- stall  in  1  downstream cannot accept the current instruction
- branch_taken  in  1  redirect request
- branch_target  in  BITS  redirect PC
- instr_valid  out  1  decoded fields are valid
- instr_pc  out  BITS  PC of the current instruction
- opcode  out  OP_BITS  instr[15:11]
- rd  out  3  instr[10:8]
- ra  out  3  instr[7:5]
- rb  out  3  instr[4:2]
- imm5  out  5  instr[4:0]
- imm8  out  8  instr[7:0]
- imm11  out  11  instr[10:0]

## Operation
- State machine states:
  - IDLE: one cycle after reset.
  - FETCH: issue requests.
  - DRAIN: wait for a stale in-flight ack.
  - HALT: only when IFD_HALT_EN is defined.
- Transitions: IDLE→FETCH unconditionally. FETCH→DRAIN when a redirect arrives with a request outstanding and no ack. DRAIN→FETCH on ack.
- imem_req = (state==FETCH || state==DRAIN) && !skid_full. imem_addr = pc in FETCH, and the latched old address in DRAIN.
- Handshake: once imem_req is asserted, req and addr are held stable until imem_ack. The ack may arrive in the same cycle as the req.
- On accepted ack in FETCH:
  - pc <= pc+1, modulo 2^BITS; 16'hFFFF wraps to 0.
  - Data goes into the IR if it is free (!instr_valid || !stall); otherwise into the skid register.
- Consume: when instr_valid && !stall, the IR takes the skid entry if one is present; otherwise instr_valid drops, unless a new ack arrives that cycle.
- No new request is issued while the skid is full.
- Redirect (branch_taken) has the highest priority:
  - IR and skid are invalidated; instr_valid=0 next cycle.
  - pc <= branch_target.
  - An ack arriving in the same cycle is discarded and the state goes to FETCH.
  - An outstanding request without an ack goes to DRAIN; that ack is discarded.
- branch_taken in DRAIN: update pc, remain in DRAIN.
- Field outputs are pure slices of the IR.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_pc=RESET_PC, all fields 0, skid empty, state=IDLE.
- Reset mid-transaction abandons any outstanding request; no drain.
- First imem_req in the 2nd cycle after rst deasserts.
- Latency from imem_ack to instr_valid/fields: 1 cycle.
- Sustained throughput: 1 instruction/cycle with single-cycle ack and no stall.
- Redirect to first new request: next cycle, or after drain ack plus 1.
- stall is sampled every cycle; outputs are held unchanged while stalled.

## Configuration
- IFD_HALT_EN:
  - Defined: when an instruction with opcode==HALT_OP enters the IR, the state goes to HALT and no further requests are issued after any outstanding ack completes. The halt instruction itself stays valid until consumed. HALT exits only on rst or branch_taken (→FETCH).
  - Undefined: HALT_OP is an ordinary opcode and the HALT state does not exist.

## Structure
- A shared package holds:
  - the state enum (IDLE, FETCH, DRAIN, HALT)
  - field bit-position constants (OP_MSB=15, OP_LSB=11, RD, RA, RB ranges)
  - INSTR_BITS=16
  - HALT_OP default
- One sub-module, ifd_skid_buf: a one-entry data+valid register with load/pop/flush.

## Test plan
- Reset, imem_ack tied to imem_req, rdata=16'h5A3C → instr_valid in cycle 3, opcode=5'b01011, rd=2, ra=1, rb=7, imm8=8'h3C, instr_pc=0.
- Stall for 3 cycles with single-cycle ack → one ack lands in the skid, imem_req=0 while it is full, no instruction lost, in-order delivery.
- branch_taken with target 16'h0040 while a request is outstanding with ack delayed 2 cycles → DRAIN; stale data discarded; next imem_addr=16'h0040.
- pc=16'hFFFF fetch → next imem_addr=16'h0000.
- rst asserted mid-request → next cycle imem_req=0, instr_valid=0, imem_addr=RESET_PC.
- With IFD_HALT_EN defined, rdata=16'hF800 → instr_valid with opcode=5'b11111, then imem_req stays 0; branch_taken to 16'h0010 resumes fetching.
